// File: rtl/control_sequencer_if.sv
// Bundle of control-sequencer signals between the instruction register, memory and datapath.
// Master is the sequencer; slave is the surrounding datapath/memory side.
interface control_sequencer_if #(
    parameter int OPW = 6
);
    logic [OPW-1:0] OpCode;
    logic           BranchTaken;
    logic           MemAck;
    logic           PCWr;
    logic [1:0]     PCSrc;
    logic           IRWr;
    logic           RegWrEn;
    logic           MemRdEn;
    logic           MemWrEn;
    logic           SPEn;
    logic [2:0]     Stage;
    logic           InstrDone;
    logic           IllegalOp;
    logic           MemTimeout;

    modport master (
        input  OpCode, BranchTaken, MemAck,
        output PCWr, PCSrc, IRWr, RegWrEn, MemRdEn, MemWrEn, SPEn,
               Stage, InstrDone, IllegalOp, MemTimeout
    );

    modport slave (
        output OpCode, BranchTaken, MemAck,
        input  PCWr, PCSrc, IRWr, RegWrEn, MemRdEn, MemWrEn, SPEn,
               Stage, InstrDone, IllegalOp, MemTimeout
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer producing per-cycle write and strobe enables.
// The current state is exported on Stage so checkers can follow the FSM directly.
module control_sequencer #(
    parameter int OPW        = 6,
    parameter int SPWAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [OPW-1:0] OP_AND   = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(4);
    localparam logic [OPW-1:0] OP_LW    = OPW'(5);
    localparam logic [OPW-1:0] OP_LWPOI = OPW'(6);
    localparam logic [OPW-1:0] OP_SW    = OPW'(7);
    localparam logic [OPW-1:0] OP_BGT   = OPW'(8);
    localparam logic [OPW-1:0] OP_BLT   = OPW'(9);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(10);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(11);
    localparam logic [OPW-1:0] OP_JMP   = OPW'(12);
    localparam logic [OPW-1:0] OP_CALL  = OPW'(13);
    localparam logic [OPW-1:0] OP_RET   = OPW'(14);
    localparam logic [OPW-1:0] OP_PUSH  = OPW'(15);
    localparam logic [OPW-1:0] OP_POP   = OPW'(16);

    localparam int CW = $clog2(SPWAIT_MAX + 1);

    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jmp;
        logic call;
        logic ret;
        logic push;
        logic pop;
        logic legal;
    } op_class_t;

    function automatic op_class_t classify(input logic [OPW-1:0] o);
        op_class_t c;
        c = '0;
        c.legal = 1'b1;
        case (o)
            OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI: c.alu    = 1'b1;
            OP_LW, OP_LWPOI:                          c.load   = 1'b1;
            OP_SW:                                    c.store  = 1'b1;
            OP_BGT, OP_BLT, OP_BEQ, OP_BNE:           c.branch = 1'b1;
            OP_JMP:                                   c.jmp    = 1'b1;
            OP_CALL:                                  c.call   = 1'b1;
            OP_RET:                                   c.ret    = 1'b1;
            OP_PUSH:                                  c.push   = 1'b1;
            OP_POP:                                   c.pop    = 1'b1;
            default:                                  c.legal  = 1'b0;
        endcase
        return c;
    endfunction

    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic [OPW-1:0] op;
    logic [CW-1:0]  wait_cnt;
    logic           timeout_q;

    op_class_t dec_cls;
    op_class_t op_cls;
    logic      mem_rd_op;
    logic      mem_wr_op;
    logic      mem_wait;
    logic      timeout_now;

    // DECODE steers from the live opcode; every later state uses the latched copy.
    assign dec_cls   = classify(bus.OpCode);
    assign op_cls    = classify(op);
    assign mem_rd_op = op_cls.load  | op_cls.ret  | op_cls.pop;
    assign mem_wr_op = op_cls.store | op_cls.call | op_cls.push;
    assign mem_wait  = (state == S_MEM) && !bus.MemAck;

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                if (dec_cls.alu || dec_cls.load || dec_cls.store || dec_cls.branch)
                    state_nxt = S_EXEC;
                else if (dec_cls.call || dec_cls.ret || dec_cls.push || dec_cls.pop)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_FETCH;
            end
            S_EXEC: begin
                if (op_cls.alu)
                    state_nxt = S_WB;
                else if (op_cls.load || op_cls.store)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_FETCH;
            end
            S_MEM: begin
                if (!bus.MemAck)
                    state_nxt = S_MEM;
                else if (op_cls.load || op_cls.pop)
                    state_nxt = S_WB;
                else
                    state_nxt = S_FETCH;
            end
            S_WB:    state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            op        <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                op <= bus.OpCode;
            if (mem_wait) begin
                if (wait_cnt != CW'(SPWAIT_MAX))
                    wait_cnt <= wait_cnt + CW'(1);
                if (timeout_now)
                    timeout_q <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // The flag is visible already in the wait cycle that brings the count to SPWAIT_MAX.
    assign timeout_now = mem_wait && (wait_cnt >= CW'(SPWAIT_MAX - 1));

    // Memory handshake: the strobe (MemRdEn/MemWrEn) is raised from the first MEM cycle and
    // held unchanged until the cycle MemAck is sampled high; that cycle completes the transfer
    // and the FSM leaves MEM, so the side effects tied to the ack cycle fire exactly once.
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       reg_wr_en;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic       sp_en;
    logic       instr_done;
    logic       illegal_op;

    always_comb begin
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        ir_wr      = 1'b0;
        reg_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        sp_en      = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                end
                S_DECODE: begin
                    if (dec_cls.jmp) begin
                        pc_wr      = 1'b1;
                        pc_src     = 2'b10;
                        instr_done = 1'b1;
                    end
                    if (!dec_cls.legal) begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (op_cls.branch) begin
                        pc_wr      = bus.BranchTaken;
                        pc_src     = 2'b01;
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_rd_en = mem_rd_op;
                    mem_wr_en = mem_wr_op;
                    if (bus.MemAck) begin
                        sp_en      = op_cls.call | op_cls.ret | op_cls.push | op_cls.pop;
                        instr_done = op_cls.store | op_cls.call | op_cls.ret | op_cls.push;
                        if (op_cls.call) begin
                            pc_wr  = 1'b1;
                            pc_src = 2'b10;
                        end
                        if (op_cls.ret) begin
                            pc_wr  = 1'b1;
                            pc_src = 2'b11;
                        end
                    end
                end
                S_WB: begin
                    reg_wr_en  = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.PCWr       = pc_wr;
    assign bus.PCSrc      = pc_src;
    assign bus.IRWr       = ir_wr;
    assign bus.RegWrEn    = reg_wr_en;
    assign bus.MemRdEn    = mem_rd_en;
    assign bus.MemWrEn    = mem_wr_en;
    assign bus.SPEn       = sp_en;
    assign bus.InstrDone  = instr_done;
    assign bus.IllegalOp  = illegal_op;
    assign bus.Stage      = reset ? 3'd0 : state;
    assign bus.MemTimeout = !reset && (timeout_q || timeout_now);

endmodule
